pc_unit: RTL and testbench

- Program counter stage for picoMIPS; sits directly downstream of the instruction decoder.
- Consumes the decoder's PCincr and branch-taken control; drives the program-memory address.
- Adds a small control FSM (RUN / WAIT / HALT), detects halt on branch-to-self, reports wrap-around, and counts consecutive stall cycles for debug LEDs.

---
 rtl/pc_unit_if.sv | 25 ++
 rtl/pc_unit.sv | 85 ++++++++
 tb/tb_pc_unit.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/pc_unit_if.sv
// Decoder <-> program counter control bus for picoMIPS.
// The master modport is the decoder side; the slave modport is the PC stage.
interface pc_unit_if #(
  parameter int unsigned PSIZE = 6,
  parameter int unsigned CSIZE = 8
);
  logic             PCincr;
  logic             PCrelbranch;
  logic [PSIZE-1:0] Branchoff;
  logic [PSIZE-1:0] PCout;
  logic             halted;
  logic             waiting;
  logic             wrap;
  logic [CSIZE-1:0] stall_cnt;

  modport master (
    output PCincr, PCrelbranch, Branchoff,
    input  PCout, halted, waiting, wrap, stall_cnt
  );

  modport slave (
    input  PCincr, PCrelbranch, Branchoff,
    output PCout, halted, waiting, wrap, stall_cnt
  );
endinterface

// File: rtl/pc_unit.sv
// picoMIPS program counter stage with RUN/WAIT/HALT control, wrap pulse
// and a saturating consecutive-stall counter for debug LEDs.
module pc_unit #(
  parameter int unsigned Psize = 6,
  parameter int unsigned Csize = 8
) (
  input  logic     clk,
  input  logic     reset,
  pc_unit_if.slave bus
);

  typedef enum logic [1:0] {
    S_RUN  = 2'd0,
    S_WAIT = 2'd1,
    S_HALT = 2'd2
  } state_t;

  state_t           r_state;
  logic [Psize-1:0] r_pc;
  logic             r_halted;
  logic             r_waiting;
  logic             r_wrap;
  logic [Csize-1:0] r_stall;

  logic             w_adv;
  logic             w_self;
  logic             w_incr_wrap;
  logic [Psize-1:0] w_next_pc;

  // Branch beats increment; a zero-offset branch is the halt idiom.
  assign w_adv       = bus.PCrelbranch | bus.PCincr;
  assign w_self      = bus.PCrelbranch & (bus.Branchoff == '0);
  assign w_incr_wrap = bus.PCincr & ~bus.PCrelbranch & (&r_pc);
  assign w_next_pc   = bus.PCrelbranch ? Psize'(r_pc + bus.Branchoff)
                                       : Psize'(r_pc + Psize'(1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_RUN;
      r_pc      <= '0;
      r_halted  <= 1'b0;
      r_waiting <= 1'b0;
      r_wrap    <= 1'b0;
      r_stall   <= '0;
    end else begin
      r_wrap <= 1'b0;
      case (r_state)
        S_RUN, S_WAIT: begin
          if (w_self) begin
            r_state   <= S_HALT;
            r_halted  <= 1'b1;
            r_waiting <= 1'b0;
          end else if (w_adv) begin
            r_state   <= S_RUN;
            r_pc      <= w_next_pc;
            r_waiting <= 1'b0;
            r_wrap    <= w_incr_wrap;
            r_stall   <= '0;
          end else begin
            r_state   <= S_WAIT;
            r_waiting <= 1'b1;
            if (r_stall != {Csize{1'b1}})
              r_stall <= Csize'(r_stall + Csize'(1));
          end
        end
        // Frozen until reset.
        S_HALT: begin
          r_state <= S_HALT;
        end
        default: begin
          r_state   <= S_RUN;
          r_halted  <= 1'b0;
          r_waiting <= 1'b0;
        end
      endcase
    end
  end

  assign bus.PCout     = r_pc;
  assign bus.halted    = r_halted;
  assign bus.waiting   = r_waiting;
  assign bus.wrap      = r_wrap;
  assign bus.stall_cnt = r_stall;

endmodule

// File: tb/tb_pc_unit.sv
// Directed self-checking bench for pc_unit with hand-computed expectations.
module tb_pc_unit;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;

  pc_unit_if #(.PSIZE(6), .CSIZE(8)) bus ();

  pc_unit #(.Psize(6), .Csize(8)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic inc, input logic br, input logic [5:0] off);
    bus.PCincr      = inc;
    bus.PCrelbranch = br;
    bus.Branchoff   = off;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    reset    = 1'b1;
    drive(1'b0, 1'b0, 6'd0);

    #2;
    chk("rst_pc",      32'(bus.PCout),     32'd0);
    chk("rst_halted",  32'(bus.halted),    32'd0);
    chk("rst_waiting", 32'(bus.waiting),   32'd0);
    chk("rst_wrap",    32'(bus.wrap),      32'd0);
    chk("rst_stall",   32'(bus.stall_cnt), 32'd0);
    #1 reset = 1'b0;

    // Plain increments 0..5
    drive(1'b1, 1'b0, 6'd0);
    for (int i = 1; i <= 5; i++) begin
      step();
      chk("inc_pc", 32'(bus.PCout), 32'(i));
      chk("inc_waiting", 32'(bus.waiting), 32'd0);
      chk("inc_stall", 32'(bus.stall_cnt), 32'd0);
    end

    // Reach PC=10, then branch -4 with PCincr also high
    repeat (5) step();
    chk("pc_at_10", 32'(bus.PCout), 32'd10);
    drive(1'b1, 1'b1, 6'b111100);
    step();
    chk("br_wins_pc", 32'(bus.PCout), 32'd6);
    chk("br_wins_wrap", 32'(bus.wrap), 32'd0);

    // 6 + 31 = 37, 37 + 26 = 63
    drive(1'b0, 1'b1, 6'd31);
    step();
    chk("br_pos_pc", 32'(bus.PCout), 32'd37);
    drive(1'b0, 1'b1, 6'd26);
    step();
    chk("pc_at_63", 32'(bus.PCout), 32'd63);

    // Increment wrap 63 -> 0, one-cycle pulse
    drive(1'b1, 1'b0, 6'd0);
    step();
    chk("wrap_pc", 32'(bus.PCout), 32'd0);
    chk("wrap_set", 32'(bus.wrap), 32'd1);
    step();
    chk("wrap_pc1", 32'(bus.PCout), 32'd1);
    chk("wrap_clear", 32'(bus.wrap), 32'd0);
    step();
    chk("pc_at_2", 32'(bus.PCout), 32'd2);

    // Branch 2 + (-3) crosses zero without wrap
    drive(1'b0, 1'b1, 6'b111101);
    step();
    chk("brneg_pc", 32'(bus.PCout), 32'd63);
    chk("brneg_wrap", 32'(bus.wrap), 32'd0);

    // Long stall: saturates at 255
    drive(1'b0, 1'b0, 6'd0);
    step();
    chk("stall_waiting", 32'(bus.waiting), 32'd1);
    chk("stall_cnt1", 32'(bus.stall_cnt), 32'd1);
    chk("stall_pc", 32'(bus.PCout), 32'd63);
    repeat (299) step();
    chk("stall_sat", 32'(bus.stall_cnt), 32'd255);
    chk("stall_pc_hold", 32'(bus.PCout), 32'd63);
    chk("stall_waiting2", 32'(bus.waiting), 32'd1);

    // One increment leaves WAIT and clears the counter (63 -> 0 wraps)
    drive(1'b1, 1'b0, 6'd0);
    step();
    chk("resume_pc", 32'(bus.PCout), 32'd0);
    chk("resume_waiting", 32'(bus.waiting), 32'd0);
    chk("resume_stall", 32'(bus.stall_cnt), 32'd0);
    chk("resume_wrap", 32'(bus.wrap), 32'd1);

    // Count to 7 then branch-to-self
    repeat (7) step();
    chk("pc_at_7", 32'(bus.PCout), 32'd7);
    drive(1'b0, 1'b1, 6'd0);
    step();
    chk("halt_set", 32'(bus.halted), 32'd1);
    chk("halt_pc", 32'(bus.PCout), 32'd7);
    chk("halt_waiting", 32'(bus.waiting), 32'd0);
    drive(1'b1, 1'b0, 6'd0);
    repeat (3) step();
    drive(1'b0, 1'b1, 6'd5);
    repeat (2) step();
    drive(1'b0, 1'b0, 6'd0);
    repeat (2) step();
    chk("halt_frozen_pc", 32'(bus.PCout), 32'd7);
    chk("halt_still", 32'(bus.halted), 32'd1);

    // Async reset out of HALT, between edges
    #2 reset = 1'b1;
    #1;
    chk("halt_rst_halted", 32'(bus.halted), 32'd0);
    chk("halt_rst_pc", 32'(bus.PCout), 32'd0);
    #1 reset = 1'b0;

    // Count to 20, stall 3 cycles, then async reset inside WAIT
    drive(1'b1, 1'b0, 6'd0);
    repeat (20) step();
    chk("pc_at_20", 32'(bus.PCout), 32'd20);
    drive(1'b0, 1'b0, 6'd0);
    repeat (3) step();
    chk("wait_before_rst", 32'(bus.waiting), 32'd1);
    chk("stall_before_rst", 32'(bus.stall_cnt), 32'd3);
    #2 reset = 1'b1;
    #1;
    chk("wrst_pc", 32'(bus.PCout), 32'd0);
    chk("wrst_waiting", 32'(bus.waiting), 32'd0);
    chk("wrst_stall", 32'(bus.stall_cnt), 32'd0);
    #1 reset = 1'b0;
    drive(1'b1, 1'b0, 6'd0);
    step();
    chk("post_rst_pc1", 32'(bus.PCout), 32'd1);
    step();
    chk("post_rst_pc2", 32'(bus.PCout), 32'd2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
